// File: rtl/logic_pll_reset_sequencer.sv
// Brings PLL lock-service channels up one at a time, then releases each clock domain a fixed delay after lock.
// Optional timeout retries are enabled by defining LOGIC_PLL_RESET_SEQUENCER_RETRY_EN.
module logic_pll_reset_sequencer #(
  parameter int unsigned     PLLS               = 2,
  parameter longint unsigned CLOCK_FREQUENCY_HZ = 64'd100_000_000,
  parameter longint unsigned LOCK_TIMEOUT_NS    = 64'd1_000_000,
  parameter longint unsigned RELEASE_DELAY_NS   = 64'd100,
  parameter int unsigned     RETRIES            = 3,
  localparam int unsigned    IDX_W              = (PLLS > 1) ? $clog2(PLLS) : 1
) (
  input  logic             aclk,
  input  logic             reset,
  input  logic             start,
  input  logic [PLLS-1:0]  locked,
  output logic [PLLS-1:0]  service_reset_n,
  output logic [PLLS-1:0]  domain_reset_n,
  output logic             ready,
  output logic             error,
  output logic [IDX_W-1:0] error_index
);

  function automatic longint unsigned ns_to_cycles(input longint unsigned ns);
    longint unsigned c;
    c = (ns * CLOCK_FREQUENCY_HZ + 64'd999_999_999) / 64'd1_000_000_000;
    return (c == 64'd0) ? 64'd1 : c;
  endfunction

  localparam longint unsigned TO_CYC  = ns_to_cycles(LOCK_TIMEOUT_NS);
  localparam longint unsigned DL_CYC  = ns_to_cycles(RELEASE_DELAY_NS);
  localparam longint unsigned MAX_CYC = (TO_CYC > DL_CYC) ? TO_CYC : DL_CYC;
  localparam int unsigned     CNT_W   = $clog2(MAX_CYC + 64'd1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TO_CYC);
  localparam logic [CNT_W-1:0] DL_LOAD = CNT_W'(DL_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(PLLS - 1);

  if (PLLS < 1 || PLLS > 16 || RETRIES < 1 || RETRIES > 15) begin : g_param_check
    $error("logic_pll_reset_sequencer: PLLS or RETRIES out of range");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_ENABLE, ST_WAIT_LOCK, ST_DELAY, ST_RUN, ST_ERROR
`ifdef LOGIC_PLL_RESET_SEQUENCER_RETRY_EN
    , ST_RETRY
`endif
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d, eidx_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [PLLS-1:0]  srn_d, drn_d, sel;
  logic             ready_d, error_d, lost;
`ifdef LOGIC_PLL_RESET_SEQUENCER_RETRY_EN
  localparam logic [3:0] RETRY_MAX = 4'(RETRIES);
  logic [3:0] rcnt, rcnt_d;
`endif

  // A released domain whose PLL has dropped lock forces a full restart.
  assign lost = |(domain_reset_n & ~locked);

  // Next-state and next-output decode.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    srn_d   = service_reset_n;
    drn_d   = domain_reset_n;
    ready_d = 1'b0;
    error_d = 1'b0;
    eidx_d  = '0;
    sel      = '0;
    sel[idx] = 1'b1;
`ifdef LOGIC_PLL_RESET_SEQUENCER_RETRY_EN
    rcnt_d = rcnt;
`endif
    if (state != ST_ERROR && !start) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      srn_d   = '0;
      drn_d   = '0;
`ifdef LOGIC_PLL_RESET_SEQUENCER_RETRY_EN
      rcnt_d  = 4'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          idx_d   = '0;
          cnt_d   = '0;
          srn_d   = '0;
          drn_d   = '0;
          state_d = ST_ENABLE;
`ifdef LOGIC_PLL_RESET_SEQUENCER_RETRY_EN
          rcnt_d  = 4'd0;
`endif
        end
        ST_ENABLE: begin
          srn_d   = service_reset_n | sel;
          cnt_d   = TO_LOAD;
          state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lost) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            srn_d   = '0;
            drn_d   = '0;
          end else if (locked[idx]) begin
            state_d = ST_DELAY;
            cnt_d   = DL_LOAD;
`ifdef LOGIC_PLL_RESET_SEQUENCER_RETRY_EN
            rcnt_d  = 4'd0;
`endif
          end else if (cnt <= CNT_ONE) begin
`ifdef LOGIC_PLL_RESET_SEQUENCER_RETRY_EN
            if (rcnt >= RETRY_MAX) begin
              state_d = ST_ERROR;
              cnt_d   = '0;
              srn_d   = '0;
              drn_d   = '0;
              error_d = 1'b1;
              eidx_d  = idx;
            end else begin
              state_d = ST_RETRY;
              cnt_d   = '0;
              srn_d   = service_reset_n & ~sel;
              rcnt_d  = rcnt + 4'd1;
            end
`else
            state_d = ST_ERROR;
            cnt_d   = '0;
            srn_d   = '0;
            drn_d   = '0;
            error_d = 1'b1;
            eidx_d  = idx;
`endif
          end else begin
            cnt_d = cnt - CNT_ONE;
          end
        end
        // Delay runs for DL_CYC cycles counted from the edge that sampled lock.
        ST_DELAY: begin
          if (lost || !locked[idx]) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            srn_d   = '0;
            drn_d   = '0;
          end else if (cnt <= CNT_ONE) begin
            cnt_d = '0;
            drn_d = domain_reset_n | sel;
            if (idx == LAST) begin
              state_d = ST_RUN;
            end else begin
              idx_d   = idx + IDX_W'(1);
              state_d = ST_ENABLE;
            end
          end else begin
            cnt_d = cnt - CNT_ONE;
          end
        end
`ifdef LOGIC_PLL_RESET_SEQUENCER_RETRY_EN
        // Service reset is low only while in RETRY; re-raised on leaving it.
        ST_RETRY: begin
          srn_d   = service_reset_n | sel;
          state_d = ST_ENABLE;
        end
`endif
        ST_RUN: begin
          if (lost) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            srn_d   = '0;
            drn_d   = '0;
          end else begin
            ready_d = 1'b1;
          end
        end
        ST_ERROR: begin
          srn_d = '0;
          drn_d = '0;
          if (!start) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            error_d = 1'b1;
            eidx_d  = error_index;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          srn_d   = '0;
          drn_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state           <= ST_IDLE;
      idx             <= '0;
      cnt             <= '0;
      service_reset_n <= '0;
      domain_reset_n  <= '0;
      ready           <= 1'b0;
      error           <= 1'b0;
      error_index     <= '0;
`ifdef LOGIC_PLL_RESET_SEQUENCER_RETRY_EN
      rcnt            <= 4'd0;
`endif
    end else begin
      state           <= state_d;
      idx             <= idx_d;
      cnt             <= cnt_d;
      service_reset_n <= srn_d;
      domain_reset_n  <= drn_d;
      ready           <= ready_d;
      error           <= error_d;
      error_index     <= eidx_d;
`ifdef LOGIC_PLL_RESET_SEQUENCER_RETRY_EN
      rcnt            <= rcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_logic_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes (cycle + value); a negedge monitor
// pops one entry for every change it sees on the DUT outputs and compares.
module tb_logic_pll_reset_sequencer;

  logic       aclk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] locked;
  logic [1:0] service_reset_n;
  logic [1:0] domain_reset_n;
  logic       ready;
  logic       error;
  logic [0:0] error_index;

  logic_pll_reset_sequencer #(
    .PLLS(2),
    .CLOCK_FREQUENCY_HZ(64'd100_000_000),
    .LOCK_TIMEOUT_NS(64'd1000),
    .RELEASE_DELAY_NS(64'd100),
    .RETRIES(2)
  ) dut (
    .aclk(aclk),
    .reset(reset),
    .start(start),
    .locked(locked),
    .service_reset_n(service_reset_n),
    .domain_reset_n(domain_reset_n),
    .ready(ready),
    .error(error),
    .error_index(error_index)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [6:0] v;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mev;
  int         checks = 0;
  int         errors = 0;
  logic [6:0] prev = 7'b0;
  logic [6:0] cur;

  // Expected output vector {service_reset_n, domain_reset_n, ready, error, error_index} at edge c.
  task automatic expect_at(input int c, input logic [1:0] s, input logic [1:0] d,
                           input logic r, input logic e, input logic x);
    ev_t ev;
    ev.c = c;
    ev.v = {s, d, r, e, x};
    exp_q.push_back(ev);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge aclk);
  endtask

  // Monitor: every output change must match the next queued expectation.
  always @(negedge aclk) begin
    cur = {service_reset_n, domain_reset_n, ready, error, error_index};
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: outputs %b at cycle %0d, no change expected", cur, cyc);
      end else begin
        mev = exp_q.pop_front();
        if (mev.c != cyc || mev.v !== cur) begin
          errors++;
          $display("FAIL output_event: got %b at cycle %0d, expected %b at cycle %0d",
                   cur, cyc, mev.v, mev.c);
        end
      end
    end
    prev = cur;
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    locked = 2'b00;
    wait_cyc(3);
    checks++;
    if ({service_reset_n, domain_reset_n, ready, error, error_index} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state: got %b, expected 0000000",
               {service_reset_n, domain_reset_n, ready, error, error_index});
    end
    reset = 1'b0;

    // Normal bring-up, then a one-cycle lock drop in RUN.
    wait_cyc(5);
    expect_at(7,   2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(38,  2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(39,  2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(80,  2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    expect_at(81,  2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
    expect_at(86,  2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(88,  2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(99,  2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(100, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(111, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    expect_at(112, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
    expect_at(116, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    wait_cyc(27);  locked[0] = 1'b1;
    wait_cyc(69);  locked[1] = 1'b1;
    wait_cyc(85);  locked[0] = 1'b0;
    wait_cyc(86);  locked[0] = 1'b1;
    // start drop together with a lock loss resolves to IDLE.
    wait_cyc(115); start = 1'b0; locked[0] = 1'b0;
    wait_cyc(116); locked[0] = 1'b1;

    // Reset asserted while channel 1 is in its release delay.
    wait_cyc(118);
    expect_at(120, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(131, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(132, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(136, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    wait_cyc(135); reset = 1'b1;
    wait_cyc(136); reset = 1'b0; start = 1'b0; locked = 2'b00;

    wait_cyc(140);
`ifdef LOGIC_PLL_RESET_SEQUENCER_RETRY_EN
    // Channel 1 never locks: two retry pulses, then error on channel 1.
    expect_at(142, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(153, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(154, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(254, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(255, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(356, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(357, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
    expect_at(458, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    expect_at(461, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    locked = 2'b01;
    start  = 1'b1;
    wait_cyc(460); start = 1'b0;
    wait_cyc(470);
`else
    // Channel 0 never locks: error on channel 0 after the timeout, no retry pulse.
    expect_at(142, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    expect_at(242, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    expect_at(246, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    wait_cyc(245); start = 1'b0;
    wait_cyc(255);
`endif

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d expected changes never seen, first due at cycle %0d",
               exp_q.size(), exp_q[0].c);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
